// File: rtl/ex_pkg.sv
// Shared definitions for the execute-to-memory stage: branch-type encoding,
// default widths, the MEM-bound payload struct and the branch-resolution helper.
package ex_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_JAL  = 3'd5;
    localparam logic [2:0] BR_JALR = 3'd6;

    typedef struct packed {
        logic [XLEN_DEF-1:0] result;
        logic [XLEN_DEF-1:0] rs2_data;
        logic [RA_W_DEF-1:0] rd;
        logic                reg_we;
        logic                mem_re;
        logic                mem_we;
    } ex_mem_t;

    // Only the flag belonging to the compare opcode is consulted; the others are garbage.
    function automatic logic br_taken(input logic [2:0] br_type, input logic f_eq,
                                      input logic f_ne, input logic f_lt, input logic f_ge);
        logic t;
        case (br_type)
            BR_BEQ:  t = f_eq;
            BR_BNE:  t = f_ne;
            BR_BLT:  t = f_lt;
            BR_BGE:  t = f_ge;
            BR_JAL:  t = 1'b1;
            BR_JALR: t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic is_branch(input logic [2:0] br_type);
        return (br_type != BR_NONE) && (br_type != 3'd7);
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready register: a main stage driving the outputs plus one
// skid entry, so in_ready comes straight from a flop.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_main_valid;
    logic [W-1:0] r_main_data;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;
    logic         w_accept;
    logic         w_drain;

    assign w_accept  = in_valid && !r_skid_valid;
    assign w_drain   = r_main_valid && out_ready;
    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;

    // Main/skid occupancy and data; flush drops valids but leaves data untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_drain) begin
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main_data  <= in_data;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid) begin
                r_main_data  <= in_data;
                r_main_valid <= 1'b1;
            end else begin
                r_skid_data  <= in_data;
                r_skid_valid <= 1'b1;
            end
        end else begin
            r_main_valid <= r_main_valid;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage with branch/jump resolution and a one-cycle fetch redirect.
// Optional branch statistics counters are enabled by defining EX_MEM_BRANCH_STATS_EN.
module ex_mem_stage
    import ex_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RA_W  = RA_W_DEF,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic            beq_,
    input  logic            bne_,
    input  logic            blt_,
    input  logic            bge_,
    input  logic [2:0]      br_type,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [RA_W-1:0] rd,
    input  logic            reg_we,
    input  logic            mem_re,
    input  logic            mem_we,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [RA_W-1:0] out_rd,
    output logic            out_reg_we,
    output logic            out_mem_re,
    output logic            out_mem_we,
`ifdef EX_MEM_BRANCH_STATS_EN
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] br_taken_count,
`endif
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    logic            w_in_ready;
    logic            w_accept;
    logic            w_taken;
    logic            w_is_jump;
    logic [XLEN-1:0] w_target;
    ex_mem_t         w_in_payload;
    ex_mem_t         w_out_payload;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    assign w_accept  = in_valid && w_in_ready;
    assign w_taken   = br_taken(br_type, beq_, bne_, blt_, bge_);
    assign w_is_jump = (br_type == BR_JAL) || (br_type == BR_JALR);
    assign w_target  = (br_type == BR_JALR) ? {alu_result[XLEN-1:1], 1'b0} : (pc + imm);

    assign w_in_payload.result   = w_is_jump ? (pc + XLEN'(32'd4)) : alu_result;
    assign w_in_payload.rs2_data = rs2_data;
    assign w_in_payload.rd       = rd;
    assign w_in_payload.reg_we   = reg_we;
    assign w_in_payload.mem_re   = mem_re;
    assign w_in_payload.mem_we   = mem_we;

    skid_buffer #(.W($bits(ex_mem_t))) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_payload)
    );

    assign in_ready     = w_in_ready;
    assign out_result   = w_out_payload.result;
    assign out_rs2_data = w_out_payload.rs2_data;
    assign out_rd       = w_out_payload.rd;
    assign out_reg_we   = w_out_payload.reg_we;
    assign out_mem_re   = w_out_payload.mem_re;
    assign out_mem_we   = w_out_payload.mem_we;

    // Redirect is a single-cycle pulse launched by the accept of a taken instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else if (flush) begin
            r_redirect_valid <= 1'b0;
        end else if (w_accept && w_taken) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_target;
        end else begin
            r_redirect_valid <= 1'b0;
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

`ifdef EX_MEM_BRANCH_STATS_EN
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_br_taken_count;

    // Saturating counters over accepted, non-flushed branch/jump instructions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_br_count       <= '0;
            r_br_taken_count <= '0;
        end else if (w_accept && !flush && is_branch(br_type)) begin
            if (r_br_count != '1) begin
                r_br_count <= r_br_count + CNT_W'(1'b1);
            end else begin
                r_br_count <= r_br_count;
            end
            if (w_taken && (r_br_taken_count != '1)) begin
                r_br_taken_count <= r_br_taken_count + CNT_W'(1'b1);
            end else begin
                r_br_taken_count <= r_br_taken_count;
            end
        end else begin
            r_br_count       <= r_br_count;
            r_br_taken_count <= r_br_taken_count;
        end
    end

    assign br_count       = r_br_count;
    assign br_taken_count = r_br_taken_count;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage (default build; stats counters
// are also checked when EX_MEM_BRANCH_STATS_EN is defined).
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        beq_, bne_, blt_, bge_;
    logic [2:0]  br_type;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        reg_we, mem_re, mem_we;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_rs2_data;
    logic [4:0]  out_rd;
    logic        out_reg_we, out_mem_re, out_mem_we;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef EX_MEM_BRANCH_STATS_EN
    logic [31:0] br_count;
    logic [31:0] br_taken_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .beq_           (beq_),
        .bne_           (bne_),
        .blt_           (blt_),
        .bge_           (bge_),
        .br_type        (br_type),
        .pc             (pc),
        .imm            (imm),
        .rs2_data       (rs2_data),
        .rd             (rd),
        .reg_we         (reg_we),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_rs2_data   (out_rs2_data),
        .out_rd         (out_rd),
        .out_reg_we     (out_reg_we),
        .out_mem_re     (out_mem_re),
        .out_mem_we     (out_mem_we),
`ifdef EX_MEM_BRANCH_STATS_EN
        .br_count       (br_count),
        .br_taken_count (br_taken_count),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] bt, input logic [31:0] alu,
                         input logic [31:0] p, input logic [31:0] im, input logic [4:0] d);
        in_valid   = v;
        br_type    = bt;
        alu_result = alu;
        pc         = p;
        imm        = im;
        rd         = d;
        rs2_data   = alu ^ 32'hA5A5_0000;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        beq_ = 1'b0; bne_ = 1'b0; blt_ = 1'b0; bge_ = 1'b0;
        reg_we = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // Streaming
        out_ready = 1'b1; reg_we = 1'b1;
        drive(1'b1, 3'd0, 32'd5, 32'h0, 32'h0, 5'd1); tick();
        chk("stream0_valid", {31'd0, out_valid}, 32'd1);
        chk("stream0_res", out_result, 32'd5);
        chk("stream0_rdy", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 3'd0, 32'd7, 32'h0, 32'h0, 5'd2); tick();
        chk("stream1_res", out_result, 32'd7);
        drive(1'b1, 3'd0, 32'd9, 32'h0, 32'h0, 5'd3); tick();
        chk("stream2_res", out_result, 32'd9);
        chk("stream2_rdy", {31'd0, in_ready}, 32'd1);
        chk("stream2_we", {31'd0, out_reg_we}, 32'd1);
        drive(1'b0, 3'd0, 32'd0, 32'h0, 32'h0, 5'd0); tick();
        chk("stream_idle", {31'd0, out_valid}, 32'd0);

        // Skid
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'h11, 32'h0, 32'h0, 5'd3); tick();
        chk("skid_a_rdy", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 3'd0, 32'h22, 32'h0, 32'h0, 5'd4); tick();
        chk("skid_full_rdy", {31'd0, in_ready}, 32'd0);
        chk("skid_hold_res", out_result, 32'h11);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0); tick();
        chk("skid_stable_res", out_result, 32'h11);
        chk("skid_stable_rd", {27'd0, out_rd}, 32'd3);
        chk("skid_stable_rs2", out_rs2_data, 32'hA5A5_0011);
        out_ready = 1'b1; tick();
        chk("skid_drain_res", out_result, 32'h22);
        chk("skid_drain_rd", {27'd0, out_rd}, 32'd4);
        chk("skid_drain_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        chk("skid_empty", {31'd0, out_valid}, 32'd0);

        // Branch flags
        reg_we = 1'b0;
        beq_ = 1'b1;
        drive(1'b1, 3'd1, 32'h0, 32'h100, 32'h20, 5'd0); tick();
        chk("beq_redir", {31'd0, redirect_valid}, 32'd1);
        chk("beq_pc", redirect_pc, 32'h120);
        chk("beq_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0); tick();
        chk("beq_pulse_end", {31'd0, redirect_valid}, 32'd0);
        beq_ = 1'b0; bne_ = 1'b1;
        drive(1'b1, 3'd1, 32'h0, 32'h100, 32'h20, 5'd0); tick();
        chk("beq_nt_redir", {31'd0, redirect_valid}, 32'd0);
        chk("beq_nt_valid", {31'd0, out_valid}, 32'd1);
        bne_ = 1'b0; blt_ = 1'b1; bge_ = 1'b0;
        drive(1'b1, 3'd4, 32'h0, 32'h100, 32'h20, 5'd0); tick();
        chk("bge_nt_redir", {31'd0, redirect_valid}, 32'd0);
        blt_ = 1'b0;

        // Jumps, back to back: two consecutive pulses
        drive(1'b1, 3'd6, 32'h2003, 32'h40, 32'h0, 5'd1); tick();
        chk("jalr_redir", {31'd0, redirect_valid}, 32'd1);
        chk("jalr_pc", redirect_pc, 32'h2002);
        chk("jalr_link", out_result, 32'h44);
        drive(1'b1, 3'd5, 32'h1234, 32'hFFFF_FFFC, 32'h8, 5'd1); tick();
        chk("jal_redir", {31'd0, redirect_valid}, 32'd1);
        chk("jal_pc_wrap", redirect_pc, 32'h4);
        chk("jal_link_wrap", out_result, 32'h0);
        drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0); tick();
        chk("jal_pulse_end", {31'd0, redirect_valid}, 32'd0);

        // Flush coinciding with an accept of a taken jump while main is stalled
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'h33, 32'h0, 32'h0, 5'd2); tick();
        drive(1'b1, 3'd5, 32'h0, 32'h200, 32'h10, 5'd2); flush = 1'b1; tick();
        flush = 1'b0;
        chk("flush_acc_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_acc_rdy", {31'd0, in_ready}, 32'd1);
        chk("flush_acc_redir", {31'd0, redirect_valid}, 32'd0);
        // Flush with skid full
        drive(1'b1, 3'd0, 32'h44, 32'h0, 32'h0, 5'd2); tick();
        drive(1'b1, 3'd0, 32'h55, 32'h0, 32'h0, 5'd2); tick();
        chk("fill_rdy", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 3'd0, 32'h66, 32'h0, 32'h0, 5'd2); flush = 1'b1; tick();
        flush = 1'b0;
        chk("flush_full_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_full_rdy", {31'd0, in_ready}, 32'd1);

        // Reset mid-stall
        mem_we = 1'b1;
        beq_ = 1'b1;
        drive(1'b1, 3'd1, 32'h77, 32'h300, 32'h4, 5'd7); tick();
        drive(1'b1, 3'd0, 32'h88, 32'h0, 32'h0, 5'd8); tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        chk("rst2_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_result", out_result, 32'd0);
        chk("rst2_rd", {27'd0, out_rd}, 32'd0);
        chk("rst2_memwe", {31'd0, out_mem_we}, 32'd0);
        chk("rst2_redir_pc", redirect_pc, 32'd0);
        chk("rst2_rdy", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1; tick();
        chk("rst2_no_ghost", {31'd0, out_valid}, 32'd0);

`ifdef EX_MEM_BRANCH_STATS_EN
        chk("stats_zero", br_count, 32'd0);
        drive(1'b1, 3'd1, 32'h0, 32'h0, 32'h4, 5'd0); tick();
        beq_ = 1'b0;
        drive(1'b1, 3'd1, 32'h0, 32'h0, 32'h4, 5'd0); tick();
        drive(1'b1, 3'd0, 32'h0, 32'h0, 32'h4, 5'd0); tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0); tick();
        chk("stats_br", br_count, 32'd2);
        chk("stats_taken", br_taken_count, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
